// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch slice: datapath widths, the PC step,
// the fetch FSM state type and the fetch-buffer entry layout.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH,
    S_FLUSH,
    S_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Registered {pc, inst} buffer between instruction memory and decode.
// Clear has priority over push/pop; the head is always read from storage.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_clear,
  input  logic [XLEN-1:0]         i_pc,
  input  logic [INST_W-1:0]       i_inst,
  output logic [XLEN-1:0]         o_pc,
  output logic [INST_W-1:0]       o_inst,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty,
  output logic                    o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_pc   = r_mem[r_rptr].pc;
  assign o_inst = r_mem[r_rptr].inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{pc: i_pc, inst: i_inst};
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, in-order imem req/gnt/rvalid tracking, redirect
// flush with stale-response discard. Define IFETCH_MISALIGN_CHK_EN for fetch_fault.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   pc_out,
  input  logic              inst_ready
`ifdef IFETCH_MISALIGN_CHK_EN
  ,
  output logic              fetch_fault
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic            r_fault;

  logic [CW-1:0]   w_out_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic            w_fault_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_misalign;
  logic [CW:0]     w_occ;
  logic            w_issue;
  logic            w_gnt_hs;
  logic            w_resp;
  logic            w_resp_keep;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic            w_full;

  assign w_redir_pc = redirect_pc & ~XLEN'(3);

`ifdef IFETCH_MISALIGN_CHK_EN
  assign w_misalign  = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = r_fault;
`else
  assign w_misalign  = 1'b0;
`endif

  // FIFO entries plus in-flight requests never exceed DEPTH, so a granted
  // response always has a slot and req can only fall on gnt or redirect.
  assign w_occ     = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_issue   = (r_state == S_FETCH) && !redirect_valid && (w_occ < OCC_MAX);
  assign imem_req  = w_issue && rst;
  assign imem_addr = r_fetch_pc;

  assign w_gnt_hs    = imem_req && imem_gnt;
  assign w_resp      = imem_rvalid && (r_outstanding != '0);
  assign w_resp_keep = w_resp && !redirect_valid && (r_discard == '0);
  assign w_pop       = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid  = !w_empty;

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_gnt_hs && !w_resp) begin
      w_out_nxt = r_outstanding + CW'(1);
    end else if (!w_gnt_hs && w_resp) begin
      w_out_nxt = r_outstanding - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_fault_nxt   = r_fault;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_discard_nxt = w_out_nxt;
      w_fault_nxt   = w_misalign;
      if (w_out_nxt != '0) begin
        w_state_nxt = S_FLUSH;
      end else if (w_misalign) begin
        w_state_nxt = S_FAULT;
      end else begin
        w_state_nxt = S_FETCH;
      end
    end else begin
      case (r_state)
        S_FLUSH: begin
          if (w_resp) begin
            w_discard_nxt = r_discard - CW'(1);
            if (r_discard == CW'(1)) begin
              w_state_nxt = r_fault ? S_FAULT : S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      r_discard     <= w_discard_nxt;
      r_fault       <= w_fault_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
      end else begin
        if (w_gnt_hs) begin
          r_fetch_pc <= r_fetch_pc + PC_INC;
        end
        if (w_resp_keep) begin
          r_resp_pc <= r_resp_pc + PC_INC;
        end
      end
    end
  end

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_resp_keep),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_pc    (r_resp_pc),
    .i_inst  (imem_rdata),
    .o_pc    (pc_out),
    .o_inst  (inst_out),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid && (r_outstanding == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_resp_keep && w_full));

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a memory model answers handshakes, a
// path-epoch reference predicts delivered instructions, a monitor compares.
module tb_ifetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_ready = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_ready     (inst_ready)
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } pend_t;

  exp_t  sb_q[$];
  pend_t mem_q[$];

  int checks   = 0;
  int failures = 0;

  // reference state
  logic [31:0] m_pc    = RESET_PC;
  int          m_occ   = 0;
  int unsigned m_epoch = 0;
  logic        m_fault = 1'b0;
  int unsigned cyc     = 0;

  // stimulus knobs, changed only on posedge
  int unsigned p_gnt = 100, p_ready = 100, p_rv = 100, p_redir = 0;
  int unsigned lat_min = 1, lat_max = 1;
  int unsigned rst_hold = 3;
  logic        redir_req = 1'b0;
  logic [31:0] redir_tgt = '0;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // stimulus, memory model and reference update
  initial begin
    pend_t       p;
    logic        exp_req;
    logic        model_pop;
    int          stale;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_hold > 0) begin
        rst = 1'b0;
        rst_hold--;
      end else begin
        rst = 1'b1;
      end
      imem_gnt   = ($urandom % 100) < p_gnt;
      inst_ready = ($urandom % 100) < p_ready;
      if (redir_req) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_tgt;
        redir_req      = 1'b0;
      end else if (($urandom % 100) < p_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom & 32'h0000_0FFC) | ((($urandom % 8) == 0) ? 32'd2 : 32'd0);
      end else begin
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
      end
      imem_rvalid = rst && (mem_q.size() > 0) && (cyc >= mem_q[0].due) && (($urandom % 100) < p_rv);
      imem_rdata  = imem_rvalid ? inst_of(mem_q[0].addr) : $urandom;
      #2;
      stale = 0;
      foreach (mem_q[i]) begin
        if (mem_q[i].epoch != m_epoch) stale++;
      end
      exp_req = rst && !redirect_valid && !m_fault && (stale == 0) &&
                ((m_occ + mem_q.size()) < DEPTH);
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
`endif
      if (!rst) begin
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_out", inst_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        m_pc    = RESET_PC;
        m_occ   = 0;
        m_fault = 1'b0;
        mem_q.delete();
        sb_q.delete();
      end else begin
        model_pop = (m_occ > 0) && inst_ready && !redirect_valid;
        if (imem_rvalid) begin
          p = mem_q.pop_front();
          if ((p.epoch == m_epoch) && !redirect_valid) begin
            sb_q.push_back('{pc: p.addr, inst: inst_of(p.addr)});
            m_occ++;
          end
        end
        if (model_pop) m_occ--;
        if (imem_req && imem_gnt) begin
          mem_q.push_back('{addr: imem_addr, epoch: m_epoch,
                            due: cyc + $urandom_range(lat_max, lat_min)});
          m_pc = m_pc + 32'd4;
        end
        if (redirect_valid) begin
          m_epoch++;
          m_occ = 0;
          sb_q.delete();
          m_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHK_EN
          m_fault = (redirect_pc[1:0] != 2'b00);
`endif
        end
      end
    end
  end

  // monitor: every presented head must be the oldest live expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, sb_q.size() != 0});
        if (inst_valid && (sb_q.size() > 0)) begin
          e = sb_q[0];
          chk("pc_out", pc_out, e.pc);
          chk("inst_out", inst_out, e.inst);
          if (inst_ready && !redirect_valid) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic wait_cyc(int unsigned n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_redirect(logic [31:0] tgt);
    redir_tgt = tgt;
    redir_req = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    // streaming from reset, single-cycle memory
    wait_cyc(16);

    // decode stalled: two requests, buffer full, head at RESET_PC
    p_ready  = 0;
    rst_hold = 2;
    wait_cyc(14);
    @(negedge clk);
    #3;
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_valid", {31'd0, inst_valid}, 32'd1);
    chk("stall_pc", pc_out, 32'h0);
    @(posedge clk);
    p_ready = 100;
    wait_cyc(8);

    // grant withheld, address must hold
    p_gnt = 0;
    wait_cyc(4);
    p_gnt = 100;
    wait_cyc(6);

    // long latency so two requests are in flight at the redirect
    lat_min = 4;
    lat_max = 4;
    wait_cyc(6);
    do_redirect(32'h0000_0100);
    wait_cyc(14);

    // redirect while responses and grants stream every cycle
    lat_min = 1;
    lat_max = 1;
    wait_cyc(6);
    do_redirect(32'h0000_0040);
    wait_cyc(10);

    // misaligned target
    do_redirect(32'h0000_0102);
    wait_cyc(8);
`ifdef IFETCH_MISALIGN_CHK_EN
    @(negedge clk);
    #3;
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("fault_noreq", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    do_redirect(32'h0000_0200);
    wait_cyc(8);
`endif

    // randomized traffic with occasional mid-run resets
    p_gnt   = 70;
    p_ready = 70;
    p_rv    = 70;
    p_redir = 3;
    lat_min = 1;
    lat_max = 5;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1000);
      rst_hold = 1;
    end
    wait_cyc(500);

    p_redir = 0;
    p_rv    = 100;
    p_ready = 100;
    wait_cyc(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
